// File: rtl/layer2_avgpool_if.sv
// Bus between the layer2 average-pool engine and its controller / layer1 and
// layer2 memories. The engine uses the slave modport.
interface layer2_avgpool_if;
   logic        start;
   logic        busy;
   logic        done;
   logic        crd;
   logic [11:0] caddr_rd;
   logic [12:0] cdata_rd;
   logic        lwr;
   logic [7:0]  laddr_wr;
   logic [12:0] ldata_wr;
   logic [12:0] max_val;
   logic [7:0]  max_idx;

   modport slave (
      input  start,
      input  cdata_rd,
      output busy,
      output done,
      output crd,
      output caddr_rd,
      output lwr,
      output laddr_wr,
      output ldata_wr,
      output max_val,
      output max_idx
   );

   modport master (
      output start,
      output cdata_rd,
      input  busy,
      input  done,
      input  crd,
      input  caddr_rd,
      input  lwr,
      input  laddr_wr,
      input  ldata_wr,
      input  max_val,
      input  max_idx
   );
endinterface

// File: rtl/layer2_avgpool.sv
// 2x2 stride-2 rounded average pooling of a 32x32 layer1 map into a 16x16
// layer2 map, tracking the largest layer2 value and its lowest address.
module layer2_avgpool (
   input  logic               clk,
   input  logic               reset,
   layer2_avgpool_if.slave    bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_FINISH
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [7:0]  r_o;
   logic [2:0]  r_k;
   logic [14:0] r_sum;

   logic        r_busy;
   logic        r_done;
   logic        r_crd;
   logic [11:0] r_caddr_rd;
   logic        r_lwr;
   logic [7:0]  r_laddr_wr;
   logic [12:0] r_ldata_wr;
   logic [12:0] r_max_val;
   logic [7:0]  r_max_idx;

   logic [14:0] w_sum_nxt;
   logic [14:0] w_rnd;
   logic [12:0] w_avg;
   logic [11:0] w_rd_addr;
   logic        w_rd_last;

   // Four 13-bit inputs plus the rounding constant peak at 32766, so 15 bits never wrap.
   assign w_sum_nxt = r_sum + {2'b00, bus.cdata_rd};
   assign w_rnd     = w_sum_nxt + 15'd2;
   assign w_avg     = w_rnd[14:2];
   assign w_rd_addr = {2'b00, r_o[7:4], r_k[1], r_o[3:0], r_k[0]};
   assign w_rd_last = (r_state == S_READ) && (r_k == 3'd3);

   // NOTE: every signal driven from always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (bus.start) w_state_nxt = S_READ;
         S_READ:   if (r_k == 3'd4) w_state_nxt = S_WRITE;
         S_WRITE:  w_state_nxt = (r_o == 8'd255) ? S_FINISH : S_READ;
         S_FINISH: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Strobes are registered from the next state so they are high exactly in their own state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_done <= 1'b0;
         r_lwr  <= 1'b0;
         r_crd  <= 1'b0;
      end else begin
         r_done <= (w_state_nxt == S_FINISH);
         r_lwr  <= (w_state_nxt == S_WRITE);
         r_crd  <= (w_state_nxt == S_READ) && !w_rd_last;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_o        <= 8'd0;
         r_k        <= 3'd0;
         r_sum      <= 15'd0;
         r_busy     <= 1'b0;
         r_caddr_rd <= 12'd0;
         r_laddr_wr <= 8'd0;
         r_ldata_wr <= 13'd0;
         r_max_val  <= 13'd0;
         r_max_idx  <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_busy    <= 1'b1;
                  r_o       <= 8'd0;
                  r_k       <= 3'd0;
                  r_sum     <= 15'd0;
                  r_max_val <= 13'd0;
                  r_max_idx <= 8'd0;
               end
            end
            S_READ: begin
               // Address for input k is registered now; its data is accumulated next cycle.
               if (r_k <= 3'd3) r_caddr_rd <= w_rd_addr;
               if (r_k != 3'd0) r_sum <= w_sum_nxt;
               if (r_k == 3'd4) begin
                  r_laddr_wr <= r_o;
                  r_ldata_wr <= w_avg;
               end else begin
                  r_k <= r_k + 3'd1;
               end
            end
            S_WRITE: begin
               r_sum <= 15'd0;
               r_k   <= 3'd0;
               // Strict compare: ties keep the earlier (lower) layer2 address.
               if (r_ldata_wr > r_max_val) begin
                  r_max_val <= r_ldata_wr;
                  r_max_idx <= r_o;
               end
               if (r_o != 8'd255) r_o <= r_o + 8'd1;
            end
            S_FINISH: begin
               r_busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.crd      = r_crd;
   assign bus.caddr_rd = r_caddr_rd;
   assign bus.lwr      = r_lwr;
   assign bus.laddr_wr = r_laddr_wr;
   assign bus.ldata_wr = r_ldata_wr;
   assign bus.max_val  = r_max_val;
   assign bus.max_idx  = r_max_idx;

endmodule

// File: tb/tb_layer2_avgpool.sv
// Directed bench for layer2_avgpool: a layer1 memory model, an expected-write
// queue filled at stimulus time, and a negedge monitor that pops and compares.
module tb_layer2_avgpool;

   typedef struct {
      logic [7:0]  addr;
      logic [12:0] data;
   } wr_t;

   logic clk;
   logic reset;

   layer2_avgpool_if u_if ();

   layer2_avgpool u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave)
   );

   logic [12:0] mem [1024];
   logic [12:0] l2  [256];
   wr_t         exp_q [$];

   int          n_checks;
   int          n_fails;
   int          n_done;
   int          a_idx;
   bit          addr_chk_en;
   bit          prev_crd;
   logic [12:0] exp_max_val;
   logic [7:0]  exp_max_idx;

   assign u_if.cdata_rd = mem[u_if.caddr_rd[9:0]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: scoreboard pop on every write, done counting, read-address sequence.
   always @(negedge clk) begin
      if (u_if.lwr) begin
         l2[u_if.laddr_wr] = u_if.ldata_wr;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL unexpected_write: addr %0d data 0x%0h with nothing expected",
                     u_if.laddr_wr, u_if.ldata_wr);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("write_addr", {24'd0, u_if.laddr_wr}, {24'd0, e.addr});
            check("write_data", {19'd0, u_if.ldata_wr}, {19'd0, e.data});
         end
      end
      if (u_if.done) n_done++;
      if (addr_chk_en && prev_crd) begin
         logic [7:0]  o;
         logic [1:0]  kk;
         logic [11:0] ea;
         o  = 8'(a_idx >> 2);
         kk = 2'(a_idx);
         ea = {2'b00, o[7:4], kk[1], o[3:0], kk[0]};
         check("caddr_seq", {20'd0, u_if.caddr_rd}, {20'd0, ea});
         a_idx++;
      end
      prev_crd = u_if.crd;
   end

   function automatic logic [12:0] model(input int o);
      int r, c, base, s;
      r    = o >> 4;
      c    = o & 15;
      base = r * 64 + c * 2;
      s    = int'(mem[base]) + int'(mem[base + 1]) + int'(mem[base + 32]) + int'(mem[base + 33]);
      return 13'((s + 2) >> 2);
   endfunction

   task automatic load_expect();
      logic [12:0] v;
      exp_max_val = 13'd0;
      exp_max_idx = 8'd0;
      for (int o = 0; o < 256; o++) begin
         wr_t e;
         v      = model(o);
         e.addr = 8'(o);
         e.data = v;
         exp_q.push_back(e);
         if (v > exp_max_val) begin
            exp_max_val = v;
            exp_max_idx = 8'(o);
         end
      end
      for (int o = 0; o < 256; o++) l2[o] = 13'h1AAA;
   endtask

   task automatic fill(input logic [12:0] v);
      for (int i = 0; i < 1024; i++) mem[i] = v;
   endtask

   task automatic run_pass(input bit hold);
      int n;
      load_expect();
      @(negedge clk);
      u_if.start = 1'b1;
      @(negedge clk);
      if (!hold) u_if.start = 1'b0;
      check("busy_after_start", {31'd0, u_if.busy}, 32'd1);
      n = 0;
      while (!u_if.done && n < 3000) begin
         @(negedge clk);
         n++;
         if (hold && n == 1000) u_if.start = 1'b0;
      end
      check("pass_cycles", n, 1536);
      check("queue_drained", exp_q.size(), 0);
      check("max_val", {19'd0, u_if.max_val}, {19'd0, exp_max_val});
      check("max_idx", {24'd0, u_if.max_idx}, {24'd0, exp_max_idx});
      exp_q.delete();
      @(negedge clk);
      check("busy_after_finish", {31'd0, u_if.busy}, 32'd0);
      check("done_one_cycle", {31'd0, u_if.done}, 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},  {31'd0, u_if.busy}, 32'd0);
      check({tag, "_done"},  {31'd0, u_if.done}, 32'd0);
      check({tag, "_crd"},   {31'd0, u_if.crd}, 32'd0);
      check({tag, "_caddr"}, {20'd0, u_if.caddr_rd}, 32'd0);
      check({tag, "_lwr"},   {31'd0, u_if.lwr}, 32'd0);
      check({tag, "_laddr"}, {24'd0, u_if.laddr_wr}, 32'd0);
      check({tag, "_ldata"}, {19'd0, u_if.ldata_wr}, 32'd0);
      check({tag, "_maxv"},  {19'd0, u_if.max_val}, 32'd0);
      check({tag, "_maxi"},  {24'd0, u_if.max_idx}, 32'd0);
   endtask

   initial begin
      int  done0;
      bit  found;
      n_checks    = 0;
      n_fails     = 0;
      n_done      = 0;
      a_idx       = 0;
      addr_chk_en = 1'b0;
      prev_crd    = 1'b0;
      u_if.start  = 1'b0;
      reset       = 1'b0;
      fill(13'd0);

      // Reset state, then idle with start low.
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_no_busy", {31'd0, u_if.busy}, 32'd0);
      check("idle_no_crd", {31'd0, u_if.crd}, 32'd0);

      // Uniform 1.0 input.
      fill(13'h0010);
      run_pass(1'b0);
      check("uni_l2_0", {19'd0, l2[0]}, 32'h10);
      check("uni_l2_255", {19'd0, l2[255]}, 32'h10);
      check("uni_maxv", {19'd0, u_if.max_val}, 32'h10);
      check("uni_maxi", {24'd0, u_if.max_idx}, 32'd0);

      // Rounding: sum 2 -> 1 (half up), sum 1 -> 0, sum 6 -> 2.
      fill(13'd0);
      mem[0] = 13'd1;  mem[1] = 13'd1;
      mem[2] = 13'd1;
      mem[4] = 13'd2;  mem[5] = 13'd1;  mem[36] = 13'd2;  mem[37] = 13'd1;
      run_pass(1'b0);
      check("rnd_l2_0", {19'd0, l2[0]}, 32'd1);
      check("rnd_l2_1", {19'd0, l2[1]}, 32'd0);
      check("rnd_l2_2", {19'd0, l2[2]}, 32'd2);
      check("rnd_maxi", {24'd0, u_if.max_idx}, 32'd2);

      // Full scale: no wrap.
      fill(13'h1FFF);
      run_pass(1'b0);
      check("full_l2_0", {19'd0, l2[0]}, 32'h1FFF);
      check("full_l2_137", {19'd0, l2[137]}, 32'h1FFF);
      check("full_maxv", {19'd0, u_if.max_val}, 32'h1FFF);

      // Single peak at the last layer1 address.
      fill(13'd0);
      mem[1023] = 13'h0800;
      run_pass(1'b0);
      check("peak_l2_255", {19'd0, l2[255]}, 32'h200);
      check("peak_l2_254", {19'd0, l2[254]}, 32'd0);
      check("peak_maxi", {24'd0, u_if.max_idx}, 32'd255);
      check("peak_maxv", {19'd0, u_if.max_val}, 32'h200);

      // Equal peaks at layer2 17 and 200: lower index wins.
      fill(13'd0);
      mem[66]  = 13'h0800;
      mem[784] = 13'h0800;
      run_pass(1'b0);
      check("tie_l2_17", {19'd0, l2[17]}, 32'h200);
      check("tie_l2_200", {19'd0, l2[200]}, 32'h200);
      check("tie_maxi", {24'd0, u_if.max_idx}, 32'd17);

      // Reset while working on output 100.
      fill(13'h0010);
      load_expect();
      @(negedge clk);
      u_if.start = 1'b1;
      @(negedge clk);
      u_if.start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(negedge clk);
         if (u_if.lwr && u_if.laddr_wr == 8'd99) found = 1'b1;
      end
      check("reached_o100", {31'd0, found}, 32'd1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check_all_zero("abort");
      exp_q.delete();
      repeat (4) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      check("abort_idle_busy", {31'd0, u_if.busy}, 32'd0);
      fill(13'd0);
      mem[66]  = 13'h0800;
      mem[784] = 13'h0800;
      run_pass(1'b0);
      check("rerun_maxi", {24'd0, u_if.max_idx}, 32'd17);

      // Start held high across most of a pass; read addresses checked in order.
      fill(13'd0);
      for (int i = 0; i < 1024; i++) mem[i] = 13'(i * 7);
      done0       = n_done;
      a_idx       = 0;
      addr_chk_en = 1'b1;
      run_pass(1'b1);
      addr_chk_en = 1'b0;
      repeat (10) @(negedge clk);
      check("hold_done_pulses", n_done - done0, 1);
      check("hold_addr_count", a_idx, 1024);
      check("hold_idle_busy", {31'd0, u_if.busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/layer2_avgpool.md
LAYER2_AVGPOOL -- requirements
Module: layer2_avgpool

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low (asserted at 0).
REQ-004 SHALL have port start, input, 1 bit: begin one 256-output pass; sampled in IDLE only.
REQ-005 SHALL have port busy, output reg, 1 bit: high from the edge after start is accepted until FINISH is left.
REQ-006 SHALL have port done, output reg, 1 bit: one-cycle pulse in FINISH.
REQ-007 SHALL have port crd, output reg, 1 bit: layer1 read enable.
REQ-008 SHALL have port caddr_rd, output reg, 12 bits: layer1 read address; bits [11:10] always 0.
REQ-009 SHALL have port cdata_rd, input, 13 bits: layer1 read data, unsigned, 9 integer + 4 fraction bits; combinational on caddr_rd.
REQ-010 SHALL have port lwr, output reg, 1 bit: layer2 write strobe.
REQ-011 SHALL have port laddr_wr, output reg, 8 bits: layer2 write address.
REQ-012 SHALL have port ldata_wr, output reg, 13 bits: layer2 write data, same format as cdata_rd.
REQ-013 SHALL have port max_val, output reg, 13 bits: largest layer2 value of the current/last pass.
REQ-014 SHALL have port max_idx, output reg, 8 bits: layer2 address of max_val.

Function
REQ-015 SHALL reduce the 32x32 layer1 map to a 16x16 layer2 map by 2x2, stride-2 rounded averaging.
REQ-016 SHALL process outputs o = 0..255 in ascending order; o[7:4]=row r, o[3:0]=column c.
REQ-017 SHALL read the four inputs in the order (dy,dx) = (0,0),(0,1),(1,0),(1,1), at caddr_rd = {2'b00, r, dy, c, dx}.
REQ-018 SHALL use FSM states IDLE, READ, WRITE, FINISH.
REQ-019 IDLE: start=1 -> READ with busy<=1, o<=0, sum<=0, max_val<=0, max_idx<=0; start=0 -> stay.
REQ-020 READ: 3-bit counter k=0..4; k=0..3 registers caddr_rd for input k with crd=1; k=1..4 adds cdata_rd (input k-1) to a 15-bit sum; after k=4 -> WRITE.
REQ-021 WRITE (one cycle): lwr=1, crd=0, laddr_wr=o, ldata_wr=(sum+2)>>2 truncated to 13 bits; then clear sum and k.
REQ-022 WRITE: if the new value > max_val (strictly), update max_val and max_idx=o, so ties keep the lowest index.
REQ-023 WRITE: o<255 -> o<=o+1, back to READ; o==255 -> FINISH.
REQ-024 The 15-bit sum SHALL NOT overflow (4*8191+2 = 32766), and the result SHALL NOT exceed 8191.
REQ-025 FINISH (one cycle): done=1, busy<=0, lwr=0, crd=0; then -> IDLE.
REQ-026 lwr SHALL be high only in WRITE, and crd only in READ with k<=3.
REQ-027 Per output, timing SHALL be 6 cycles, so a full pass is 1536 cycles from leaving IDLE to entering FINISH.
REQ-028 start SHALL be ignored while busy=1 or in FINISH.
REQ-029 After FINISH, max_val, max_idx, laddr_wr and ldata_wr SHALL hold until the next accepted start.

Reset
REQ-030 reset=0 SHALL immediately force state IDLE and set every output and internal register to 0 (busy, done, crd, caddr_rd, lwr, laddr_wr, ldata_wr, max_val, max_idx, o, k, sum).
REQ-031 Reset mid-pass SHALL abort with no further lwr pulses; the next start restarts at o=0.
REQ-032 After reset release, the block SHALL stay in IDLE until start=1 is sampled.

Verification
REQ-033 Test: layer1 all 16'h? values 13'h0010 (1.0), start pulse -> 256 writes of 13'h0010 to addresses 0..255, done after 1536+ cycles, max_val=13'h0010, max_idx=0.
REQ-034 Test: inputs (0,0)=1,(0,1)=1,(1,0)=0,(1,1)=0 LSB at r=c=0 -> sum 2, ldata_wr=13'h0001 at address 0 (round half up).
REQ-035 Test: all layer1 = 13'h1FFF -> every ldata_wr = 13'h1FFF, no wrap.
REQ-036 Test: single layer1 peak 13'h0800 at address 1023, others 0 -> only layer2 address 255 = 13'h0200; max_idx=255; equal peaks at layer2 addresses 17 and 200 -> max_idx=17.
REQ-037 Test: reset=0 during o=100 -> all outputs 0 at once, no lwr until new start; the rerun's first write is address 0.
REQ-038 Test: start held high during a pass -> exactly 256 writes and one done pulse; checker confirms caddr_rd sequence and [11:10]=0.
